// File: rtl/sub_16bit_serial.sv
// rtl/sub_16bit_serial.sv - bit-serial unsigned subtractor with borrow-in/out, LSB first
module sub_16bit_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  // one full-subtractor cell applied to the current LSBs of the operand shifters
  always_comb begin
    d_bit     = a_sr[0] ^ b_sr[0] ^ br;
    br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    diff_next = {d_bit, diff[WIDTH-1:1]};
    last_bit  = (cnt == LAST);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and accept decode; the DONE->IDLE edge doubles as an accept
  // slot so that a continuously held start yields one result every WIDTH+1 cycles
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // status flags registered from the next state so they line up with the transition edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

  // operand capture, bit-serial shifting and final result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      br   <= b_in;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_next;
      diff <= diff_next;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        b_out <= br_next;
        zero  <= (diff_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_sub_16bit_serial.sv
// tb/tb_sub_16bit_serial.sv - directed and random checks of sub_16bit_serial against an arithmetic model
module tb_sub_16bit_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        b_out;
  logic        zero;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  sub_16bit_serial #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                               input logic tbin);
    int e;
    logic [15:0] ed;
    e  = int'(ta) - int'(tb_v) - int'(tbin);
    ed = e[15:0];
    check({tag, ".diff"},  diff, ed);
    check({tag, ".b_out"}, 16'(b_out), 16'(e < 0));
    check({tag, ".zero"},  16'(zero), 16'(ed == 16'h0000));
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tbin);
    int n;
    logic [15:0] held;
    @(negedge clk);
    a = ta; b = tb_v; b_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_k"}, 16'(busy), 16'd1);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 40);
    check({tag, ".latency"}, 16'(n), 16'd16);
    check({tag, ".busy_done"}, 16'(busy), 16'd0);
    expect_result(tag, ta, tb_v, tbin);
    held = diff;
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 16'(done), 16'd0);
    check({tag, ".hold"}, diff, held);
  endtask

  initial begin
    int base;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",  16'(busy),  16'd0);
    check("rst.done",  16'(done),  16'd0);
    check("rst.diff",  diff,       16'd0);
    check("rst.b_out", 16'(b_out), 16'd0);
    check("rst.zero",  16'(zero),  16'd0);
    @(negedge clk); rst = 1'b0;

    do_op("z0",   16'h0000, 16'h0000, 1'b0);
    do_op("z1",   16'h0000, 16'h0000, 1'b1);
    do_op("6m5",  16'h0006, 16'h0005, 1'b0);
    do_op("7mA",  16'h0007, 16'h000A, 1'b1);
    do_op("ffff", 16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 6; i++)
      do_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));

    // second start mid-run must be ignored
    base = done_cnt;
    @(negedge clk); a = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 16'hFFFF; b = 16'h0000;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("ign.done",  16'(done), 16'd1);
    check("ign.busy",  16'(busy), 16'd0);
    check("ign.diff",  diff, 16'h1200);
    check("ign.b_out", 16'(b_out), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("ign.count", 16'(done_cnt - base), 16'd1);

    // reset in the middle of a run
    base = done_cnt;
    @(negedge clk); a = 16'($urandom); b = 16'($urandom); b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);
    #2; rst = 1'b1; start = 1'b1;
    #1;
    check("mrst.busy", 16'(busy), 16'd0);
    check("mrst.done", 16'(done), 16'd0);
    check("mrst.diff", diff, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mrst.no_done", 16'(done_cnt - base), 16'd0);
    check("mrst.idle",    16'(busy), 16'd0);
    do_op("post_rst", 16'h0005, 16'h0006, 1'b0);

    // start held high: one result every 17 cycles
    for (int i = 0; i < 4; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
    end
    va[1] = vb[1];
    vc[1] = 1'b0;
    base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a = va[i]; b = vb[i]; b_in = vc[i]; start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 16; n++) begin
        @(negedge clk); a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
        @(posedge clk); #1;
        if (n == 16) begin
          check($sformatf("b2b%0d.done", i), 16'(done), 16'd1);
          expect_result($sformatf("b2b%0d", i), va[i], vb[i], vc[i]);
        end
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b.count", 16'(done_cnt - base), 16'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
